// File: rtl/mac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mac_pkg : shared widths, window type and FSM encoding              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package mac_pkg;

  localparam int DW   = 9;
  localparam int NTAP = 9;

  typedef logic [NTAP-1:0][DW-1:0] win_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_K = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_buffer : enable-gated shift line, oldest entry on the tap     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module line_buffer #(
  parameter int DEPTH = 32,
  parameter int DW    = 9
) (
  input  logic          clk,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  // Storage is deliberately unreset; the window is only emitted once refilled.
  logic [DEPTH-1:0][DW-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (en) begin
      r_mem <= {r_mem[DEPTH-2:0], din};
    end
  end

  assign dout = r_mem[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | conv_window_gen : 3x3 sliding window + kernel register for a MAC    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module conv_window_gen
  import mac_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     k_valid,
  input  logic [DW-1:0]            k_data,
  output logic                     k_ready,
  input  logic                     pix_valid,
  input  logic [DW-1:0]            pix_data,
  output logic                     pix_ready,
  output logic [NTAP-1:0][DW-1:0]  win_a,
  output logic [NTAP-1:0][DW-1:0]  win_b,
  output logic                     win_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] c_COL_ONE  = CW'(1);
  localparam logic [RW-1:0] c_ROW_ONE  = RW'(1);
  localparam logic [3:0]    c_K_LAST   = 4'd8;

  state_e        r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [3:0]    r_kidx;
  logic          r_win_valid;
  win_t          r_win;
  win_t          r_win_a;
  win_t          r_win_b;

  logic          w_pix_hs;
  logic          w_emit;
  logic          w_last;
  logic [DW-1:0] w_lb0_q;
  logic [DW-1:0] w_lb1_q;
  win_t          w_win_next;

  assign w_pix_hs = pix_valid && (r_state == ST_STREAM);
  assign w_emit   = (r_row > c_ROW_ONE) && (r_col > c_COL_ONE);
  assign w_last   = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);

  // lb0 holds the previous line, lb1 the line before that.
  line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
    .clk  (clk),
    .en   (w_pix_hs),
    .din  (pix_data),
    .dout (w_lb0_q)
  );

  line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
    .clk  (clk),
    .en   (w_pix_hs),
    .din  (w_lb0_q),
    .dout (w_lb1_q)
  );

  always_comb begin
    w_win_next = r_win;
    for (int r = 0; r < 3; r++) begin
      w_win_next[3*r]     = r_win[3*r + 1];
      w_win_next[3*r + 1] = r_win[3*r + 2];
    end
    w_win_next[2] = w_lb1_q;
    w_win_next[5] = w_lb0_q;
    w_win_next[8] = pix_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_kidx      <= '0;
      r_win_valid <= 1'b0;
      r_win       <= '0;
      r_win_a     <= '0;
      r_win_b     <= '0;
    end else begin
      r_win_valid <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        r_col   <= '0;
        r_row   <= '0;
        r_kidx  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state <= ST_LOAD_K;
              r_col   <= '0;
              r_row   <= '0;
              r_kidx  <= '0;
            end
          end
          ST_LOAD_K: begin
            if (k_valid) begin
              r_win_b[r_kidx] <= k_data;
              if (r_kidx == c_K_LAST) begin
                r_kidx  <= '0;
                r_state <= ST_STREAM;
              end else begin
                r_kidx <= r_kidx + 4'd1;
              end
            end
          end
          ST_STREAM: begin
            if (pix_valid) begin
              r_win <= w_win_next;
              // The output copy only moves on a complete window so it holds otherwise.
              if (w_emit) begin
                r_win_a     <= w_win_next;
                r_win_valid <= 1'b1;
              end
              if (w_last) begin
                r_col   <= '0;
                r_row   <= '0;
                r_state <= ST_DONE;
              end else if (r_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign k_ready   = (r_state == ST_LOAD_K);
  assign pix_ready = (r_state == ST_STREAM);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign win_valid = r_win_valid;
  assign win_a     = r_win_a;
  assign win_b     = r_win_b;

endmodule
`default_nettype wire
